// File: rtl/pipe_bus_ctrl_pkg.sv
// Shared widths, stall codes, bus FSM states and bus command payload
// for the pipeline controller / memory-bus arbiter.
package pipe_bus_ctrl_pkg;

  localparam int unsigned REGBUS = 32;
  localparam int unsigned SELW   = 4;
  localparam int unsigned STALLW = 6;

  localparam logic [REGBUS-1:0] ZEROWORD = REGBUS'(0);

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Stall vector bit positions: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
  localparam int unsigned STALL_IF_BIT  = 1;
  localparam int unsigned STALL_MEM_BIT = 4;

  localparam logic [STALLW-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALLW-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALLW-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALLW-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALLW-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'b00,
    BUS_IF   = 2'b01,
    BUS_MEM  = 2'b10
  } bus_state_e;

  typedef struct packed {
    logic              we;
    logic [SELW-1:0]   sel;
    logic [REGBUS-1:0] addr;
    logic [REGBUS-1:0] wdata;
  } bus_cmd_t;

  function automatic bus_cmd_t bus_cmd_reset();
    bus_cmd_t c;
    c.we    = 1'b0;
    c.sel   = SELW'(0);
    c.addr  = ZEROWORD;
    c.wdata = ZEROWORD;
    return c;
  endfunction

  // Instruction fetch is always a full-word read
  function automatic bus_cmd_t fetch_cmd(input logic [REGBUS-1:0] addr);
    bus_cmd_t c;
    c.we    = 1'b0;
    c.sel   = {SELW{1'b1}};
    c.addr  = addr;
    c.wdata = ZEROWORD;
    return c;
  endfunction

  function automatic bus_cmd_t data_cmd(input logic              we,
                                        input logic [SELW-1:0]   sel,
                                        input logic [REGBUS-1:0] addr,
                                        input logic [REGBUS-1:0] wdata);
    bus_cmd_t c;
    c.we    = we;
    c.sel   = sel;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_stall_enc.sv
// Combinational priority encoder turning the pending-request set into the
// pipeline stall vector; the highest stalled stage wins.
module ctrl_stall_enc
  import pipe_bus_ctrl_pkg::*;
(
  input  logic              req_mem,
  input  logic              stallreq_ex,
  input  logic              stallreq_id,
  input  logic              req_if,
  output logic [STALLW-1:0] stall
);

  always_comb begin
    stall = STALL_NONE;
    if (req_mem) begin
      stall = STALL_MEM;
    end else if (stallreq_ex) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end else if (req_if) begin
      stall = STALL_IF;
    end
  end

endmodule

// File: rtl/pipe_bus_ctrl.sv
// Pipeline controller: arbitrates the single memory bus between fetch and
// load/store (MEM first), buffers read data and produces the stall vector.
module pipe_bus_ctrl
  import pipe_bus_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              if_ce,
  input  logic [REGBUS-1:0] if_addr,
  output logic [REGBUS-1:0] if_rdata,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [SELW-1:0]   mem_sel,
  input  logic [REGBUS-1:0] mem_addr,
  input  logic [REGBUS-1:0] mem_wdata,
  output logic [REGBUS-1:0] mem_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [SELW-1:0]   bus_sel,
  output logic [REGBUS-1:0] bus_addr,
  output logic [REGBUS-1:0] bus_wdata,
  input  logic [REGBUS-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [STALLW-1:0] stall
);

  bus_state_e        state_q;
  bus_cmd_t          bus_cmd_q;
  logic              bus_req_q;
  logic [REGBUS-1:0] if_buf_q;
  logic [REGBUS-1:0] mem_buf_q;
  logic              if_done_q;
  logic              mem_done_q;

  logic              req_mem_c;
  logic              req_if_c;
  logic [STALLW-1:0] stall_c;

  // A port is pending until its access has completed on the bus
  assign req_mem_c = mem_ce && !mem_done_q;
  assign req_if_c  = if_ce && !if_done_q;

  ctrl_stall_enc u_stall_enc (
    .req_mem     (req_mem_c),
    .stallreq_ex (stallreq_ex),
    .stallreq_id (stallreq_id),
    .req_if      (req_if_c),
    .stall       (stall_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BUS_IDLE;
      bus_req_q  <= 1'b0;
      bus_cmd_q  <= bus_cmd_reset();
      if_buf_q   <= ZEROWORD;
      mem_buf_q  <= ZEROWORD;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      // Done flags retire once the owning stage advances; a set below wins
      if (stall_c[STALL_IF_BIT] == NOSTOP) begin
        if_done_q <= 1'b0;
      end
      if (stall_c[STALL_MEM_BIT] == NOSTOP) begin
        mem_done_q <= 1'b0;
      end

      unique case (state_q)
        BUS_IDLE: begin
          if (req_mem_c) begin
            state_q   <= BUS_MEM;
            bus_req_q <= 1'b1;
            bus_cmd_q <= data_cmd(mem_we, mem_sel, mem_addr, mem_wdata);
          end else if (req_if_c) begin
            state_q   <= BUS_IF;
            bus_req_q <= 1'b1;
            bus_cmd_q <= fetch_cmd(if_addr);
          end
        end

        BUS_IF: begin
          if (bus_ack) begin
            if_buf_q  <= bus_rdata;
            if_done_q <= 1'b1;
            bus_req_q <= 1'b0;
            state_q   <= BUS_IDLE;
          end
        end

        BUS_MEM: begin
          if (bus_ack) begin
            if (!bus_cmd_q.we) begin
              mem_buf_q <= bus_rdata;
            end
            mem_done_q <= 1'b1;
            bus_req_q  <= 1'b0;
            state_q    <= BUS_IDLE;
          end
        end

        default: begin
          state_q   <= BUS_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_cmd_q.we;
  assign bus_sel   = bus_cmd_q.sel;
  assign bus_addr  = bus_cmd_q.addr;
  assign bus_wdata = bus_cmd_q.wdata;
  assign if_rdata  = if_buf_q;
  assign mem_rdata = mem_buf_q;
  assign stall     = stall_c;

endmodule

// File: tb/tb_pipe_bus_ctrl.sv
// Self-checking bench for pipe_bus_ctrl: a bus slave pops expected accesses
// from a scoreboard queue, and the main sequence checks the stall vector.
module tb_pipe_bus_ctrl;
  import pipe_bus_ctrl_pkg::*;

  logic              clk;
  logic              rst;
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              if_ce;
  logic [REGBUS-1:0] if_addr;
  logic [REGBUS-1:0] if_rdata;
  logic              mem_ce;
  logic              mem_we;
  logic [SELW-1:0]   mem_sel;
  logic [REGBUS-1:0] mem_addr;
  logic [REGBUS-1:0] mem_wdata;
  logic [REGBUS-1:0] mem_rdata;
  logic              bus_req;
  logic              bus_we;
  logic [SELW-1:0]   bus_sel;
  logic [REGBUS-1:0] bus_addr;
  logic [REGBUS-1:0] bus_wdata;
  logic [REGBUS-1:0] bus_rdata;
  logic              bus_ack;
  logic [STALLW-1:0] stall;

  pipe_bus_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .if_ce       (if_ce),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .mem_ce      (mem_ce),
    .mem_we      (mem_we),
    .mem_sel     (mem_sel),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_sel     (bus_sel),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .stall       (stall)
  );

  typedef struct {
    bit          is_mem;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        hd;
  int          n_chk = 0;
  int          n_pass = 0;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  bit          stray_ack = 1'b0;
  bit          prev_rst = 1'b0;
  bit          armed = 1'b0;
  logic [31:0] last_if = 32'h0;
  logic [31:0] last_mem = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic push_if(input logic [31:0] addr, input logic [31:0] rdata);
    exp_t e;
    e.is_mem = 1'b0; e.we = 1'b0; e.sel = 4'hF; e.addr = addr; e.wdata = 32'h0; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic push_mem(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.is_mem = 1'b1; e.we = we; e.sel = sel; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_stall(input string tag, input logic [5:0] exp);
    #2;
    check_eq(tag, 32'(stall), 32'(exp));
  endtask

  task automatic cyc(input string tag, input logic [5:0] exp);
    sample_stall(tag, exp);
    adv();
  endtask

  // Bus slave: acks after wait_cfg wait states, checks the bus against the scoreboard head
  always begin
    @(posedge clk);
    #2;
    if (prev_rst) begin
      last_if  = 32'h0;
      last_mem = 32'h0;
      exp_q.delete();
      armed    = 1'b1;
    end
    if (armed) begin
      check_eq("if_rdata_model", if_rdata, last_if);
      check_eq("mem_rdata_model", mem_rdata, last_mem);
    end
    bus_ack   = 1'b0;
    bus_rdata = $urandom();
    if (bus_req && !rst) begin
      if (exp_q.size() == 0) begin
        check_eq("bus_unexpected", 32'(bus_req), 32'd0);
      end else begin
        hd = exp_q[0];
        check_eq("bus_addr", bus_addr, hd.addr);
        if (hd.is_mem) begin
          check_eq("bus_we", 32'(bus_we), 32'(hd.we));
          check_eq("bus_sel", 32'(bus_sel), 32'(hd.sel));
          if (hd.we) check_eq("bus_wdata", bus_wdata, hd.wdata);
        end
        if (wait_cnt == wait_cfg) begin
          bus_ack   = 1'b1;
          bus_rdata = hd.rdata;
          if (hd.is_mem) begin
            if (!hd.we) last_mem = hd.rdata;
          end else begin
            last_if = hd.rdata;
          end
          void'(exp_q.pop_front());
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      wait_cnt = 0;
      if (stray_ack) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'hBAD0BAD0;
      end
    end
    prev_rst = rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0;
    if_ce = 1'b0; if_addr = 32'h0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    adv();
    sample_stall("rst_stall", STALL_NONE);
    check_eq("rst_bus_req", 32'(bus_req), 32'd0);
    check_eq("rst_bus_we", 32'(bus_we), 32'd0);
    check_eq("rst_bus_sel", 32'(bus_sel), 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'h0);
    check_eq("rst_if_rdata", if_rdata, 32'h0);
    adv();
    rst = 1'b0;
    cyc("idle", STALL_NONE);

    // Zero-wait fetch
    wait_cfg = 0; push_if(32'h4, 32'h24010005);
    if_ce = 1'b1; if_addr = 32'h4;
    cyc("zw_c0", STALL_IF);
    sample_stall("zw_c1", STALL_IF);
    check_eq("zw_bus_req", 32'(bus_req), 32'd1);
    check_eq("zw_bus_addr", bus_addr, 32'h4);
    adv();
    sample_stall("zw_c2", STALL_NONE);
    check_eq("zw_if_rdata", if_rdata, 32'h24010005);
    adv();
    if_ce = 1'b0;
    cyc("zw_c3", STALL_NONE);

    // Collision: MEM load wins over fetch
    push_mem(1'b0, 4'hF, 32'h100, 32'h0, 32'h11223344);
    push_if(32'h8, 32'h24020007);
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h100;
    if_ce = 1'b1; if_addr = 32'h8;
    cyc("col_c0", STALL_MEM);
    sample_stall("col_c1", STALL_MEM);
    check_eq("col_bus_addr_mem", bus_addr, 32'h100);
    adv();
    sample_stall("col_c2", STALL_IF);
    check_eq("col_mem_rdata", mem_rdata, 32'h11223344);
    adv();
    mem_ce = 1'b0;
    sample_stall("col_c3", STALL_IF);
    check_eq("col_bus_addr_if", bus_addr, 32'h8);
    adv();
    sample_stall("col_c4", STALL_NONE);
    check_eq("col_if_rdata", if_rdata, 32'h24020007);
    adv();
    if_ce = 1'b0;
    cyc("col_c5", STALL_NONE);

    // Store with two wait states; EX request must not override MEM
    wait_cfg = 2; push_mem(1'b1, 4'hF, 32'h200, 32'hDEADBEEF, 32'h0);
    mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    cyc("st_c0", STALL_MEM);
    for (int i = 1; i <= 3; i++) begin
      stallreq_ex = (i == 2);
      sample_stall("st_bus", STALL_MEM);
      check_eq("st_bus_we", 32'(bus_we), 32'd1);
      check_eq("st_bus_wdata", bus_wdata, 32'hDEADBEEF);
      adv();
    end
    stallreq_ex = 1'b0;
    sample_stall("st_done", STALL_NONE);
    check_eq("st_mem_rdata", mem_rdata, 32'h11223344);
    adv();
    mem_ce = 1'b0; mem_we = 1'b0;
    cyc("st_idle", STALL_NONE);

    // Priority: EX over pending fetch, then ID while fetch result is held
    wait_cfg = 3; push_if(32'hC, 32'h24030009);
    if_ce = 1'b1; if_addr = 32'hC; stallreq_ex = 1'b1;
    cyc("pri_ex0", STALL_EX);
    cyc("pri_ex1", STALL_EX);
    stallreq_ex = 1'b0;
    cyc("pri_if2", STALL_IF);
    cyc("pri_if3", STALL_IF);
    cyc("pri_if4", STALL_IF);
    stallreq_id = 1'b1;
    cyc("pri_id5", STALL_ID);
    stallreq_id = 1'b0;
    sample_stall("pri_rel6", STALL_NONE);
    check_eq("pri_if_rdata", if_rdata, 32'h24030009);
    adv();
    if_ce = 1'b0;
    cyc("pri_idle", STALL_NONE);

    // Back-to-back fetch
    wait_cfg = 0; push_if(32'h10, 32'h8C220000); push_if(32'h14, 32'hAC230004);
    if_ce = 1'b1; if_addr = 32'h10;
    cyc("b2b_a0", STALL_IF);
    cyc("b2b_a1", STALL_IF);
    cyc("b2b_a2", STALL_NONE);
    if_addr = 32'h14;
    sample_stall("b2b_b0", STALL_IF);
    check_eq("b2b_b0_bus_req", 32'(bus_req), 32'd0);
    adv();
    sample_stall("b2b_b1", STALL_IF);
    check_eq("b2b_b1_bus_req", 32'(bus_req), 32'd1);
    check_eq("b2b_b1_bus_addr", bus_addr, 32'h14);
    adv();
    sample_stall("b2b_b2", STALL_NONE);
    check_eq("b2b_if_rdata", if_rdata, 32'hAC230004);
    adv();
    if_ce = 1'b0;
    cyc("b2b_idle", STALL_NONE);

    // Reset in the middle of a MEM access, then a stray ack
    wait_cfg = 10; push_mem(1'b0, 4'hF, 32'h300, 32'h0, 32'h55555555);
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
    cyc("mr_c0", STALL_MEM);
    sample_stall("mr_c1", STALL_MEM);
    check_eq("mr_bus_req_on", 32'(bus_req), 32'd1);
    adv();
    rst = 1'b1; mem_ce = 1'b0;
    cyc("mr_c2", STALL_NONE);
    rst = 1'b0; stray_ack = 1'b1;
    sample_stall("mr_c3", STALL_NONE);
    check_eq("mr_bus_req_off", 32'(bus_req), 32'd0);
    check_eq("mr_mem_rdata_rst", mem_rdata, 32'h0);
    adv();
    stray_ack = 1'b0;
    sample_stall("mr_c4", STALL_NONE);
    check_eq("mr_mem_rdata_stray", mem_rdata, 32'h0);
    check_eq("mr_bus_req_stray", 32'(bus_req), 32'd0);
    adv();

    // Recovery: halfword-enable load with one wait state
    wait_cfg = 1; push_mem(1'b0, 4'b0011, 32'h304, 32'h0, 32'h0000BEEF);
    mem_ce = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h304;
    cyc("rc_c0", STALL_MEM);
    cyc("rc_c1", STALL_MEM);
    cyc("rc_c2", STALL_MEM);
    sample_stall("rc_c3", STALL_NONE);
    check_eq("rc_mem_rdata", mem_rdata, 32'h0000BEEF);
    adv();
    mem_ce = 1'b0;
    cyc("rc_idle", STALL_NONE);
    adv();

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_bus_ctrl.md
# pipe_bus_ctrl

Pipeline controller and memory-bus arbiter for the five-stage core. It shares the single external memory bus between instruction fetch (IF port) and load/store (MEM port), with MEM having priority. It merges the resulting wait requests with the ID and EX stall requests into the 6-bit `stall` vector that drives PC, if_id, id_ex, ex_mem and mem_wb. It also holds each completed access's read data until the owning stage advances.

## Interface
Parameters:
- none; widths come from `REGBUS` (32) in macro.v.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high (`RSTENABLE`).
- stallreq_id  in  1  ID load-use stall request.
- stallreq_ex  in  1  EX multi-cycle stall request (madd/msub/div).
- if_ce  in  1  fetch request.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction.
- mem_ce  in  1  data access request.
- mem_we  in  1  1 = store.
- mem_sel  in  4  byte enables.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data.
- bus_req  out  1  bus cycle active.
- bus_we  out  1  write strobe.
- bus_sel  out  4  byte enables.
- bus_addr  out  32  address.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data, valid only with bus_ack.
- bus_ack  in  1  one-cycle completion pulse.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `STOP`.

## Operation
- FSM states: IDLE, IF_BUS, MEM_BUS.
- IDLE transitions:
  - mem_ce && !mem_done → MEM_BUS (priority over IF).
  - else if_ce && !if_done → IF_BUS.
  - otherwise stay.
  - On entry to a BUS state, the bus_* outputs are registered from the selected port.
- IF_BUS / MEM_BUS:
  - Hold bus_req and all bus_* outputs stable until bus_ack.
  - On bus_ack: capture bus_rdata into if_buf or mem_buf (store: mem_buf unchanged), set the matching done flag, drop bus_req, go to IDLE.
  - No preemption: a MEM request arriving during IF_BUS waits.
- Port stall requests (combinational):
  - req_mem = mem_ce && !mem_done.
  - req_if = if_ce && !if_done.
- Done flags:
  - mem_done clears at the edge where stall[4] == `NOSTOP`.
  - if_done clears at the edge where stall[1] == `NOSTOP`.
  - Clear takes precedence over nothing else: set and clear cannot coincide, because a stage cannot advance while its request is still pending.
- Read data outputs: if_rdata = if_buf, mem_rdata = mem_buf. Both hold their value until the next capture.
- Stall encoding, first match wins:
  - req_mem → 011111.
  - stallreq_ex → 001111.
  - stallreq_id → 000111.
  - req_if → 000011 (bubble into ID).
  - else → 000000.
- bus_ack in IDLE is ignored.
- bus_rdata is ignored without bus_ack.

## Timing
- Reset values (at the first rising edge with rst = 1):
  - State IDLE.
  - bus_req / bus_we 0; bus_sel 0; bus_addr / bus_wdata `ZEROWORD`.
  - if_buf / mem_buf `ZEROWORD`; both done flags 0.
  - stall is combinational from the cleared state, so it is 000000 while rst is held, provided all requests are low.
- Reset mid-transaction: bus_req drops at that edge. A later stray ack is ignored.
- Zero-wait access:
  - Request seen in cycle 0; stall asserted in cycle 0.
  - bus_req high from cycle 1; ack in cycle 1.
  - done set at the cycle-2 edge; stall releases in cycle 2.
  - Stage advances at the cycle-3 edge. Minimum of 3 cycles per access.
- Each wait state on bus_ack adds exactly 1 cycle.
- Back-to-back fetch: if_done clears at the advance edge. A new if_ce is evaluated in the next IDLE cycle, so a new bus_req appears 1 cycle after the clear.

## Structure
- macro.v gains:
  - `STALL_NONE`, `STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM` (6-bit codes above).
  - `BUS_IDLE`, `BUS_IF`, `BUS_MEM` (2-bit state codes).
- Sub-module: `ctrl_stall_enc`, a combinational priority encoder from {req_mem, stallreq_ex, stallreq_id, req_if} to stall.
- Top level holds the FSM, bus registers, buffers and done flags.

## Test plan
- Zero-wait fetch: if_ce = 1, if_addr = 0x00000004, bus_rdata = 0x24010005 with ack in the first bus cycle.
  - Expect stall 000011 for cycles 0–1.
  - Expect bus_addr 0x00000004 in cycle 1.
  - Expect if_rdata 0x24010005 and stall 000000 in cycle 2.
- Collision: if_ce and mem_ce load at 0x00000100 in the same IDLE cycle.
  - Expect the MEM access first, with stall 011111.
  - Then the IF access, with stall 000011.
  - mem_rdata equals the first ack data.
- Store, 2 wait states: mem_we = 1, mem_sel = 1111, mem_wdata = 0xDEADBEEF.
  - Expect bus_we = 1 and bus_wdata stable for 3 bus cycles.
  - Expect stall 011111 for 4 cycles total.
  - mem_rdata unchanged.
- Priority: stallreq_ex = 1 while a fetch is pending → stall 001111. Drop stallreq_ex → stall 000011 until the fetch ack.
- Reset mid-access: assert rst during MEM_BUS before the ack.
  - Expect bus_req = 0 and stall 000000 at the next edge.
  - A stray ack afterwards does not change mem_rdata (0x00000000).
